// File: rtl/alu_seq.sv
// alu_seq: valid/ready RV32I integer execution unit with a 3-state FSM (IDLE/BUSY/DONE).
// Define ALU_SEQ_MULDIV_EN to add iterative MUL/MULHU/DIVU/REMU (ops 10-13).
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             is_zero,
   output logic             overflow,
   output logic [1:0]       dbg_state_o
);

   // Handshake: a request transfers on a rising edge with in_valid && in_ready, a result
   // with out_valid && out_ready; both ready/valid outputs come only from state_q.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
`ifdef ALU_SEQ_MULDIV_EN
      BUSY = 2'd1,
`endif
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] result_q;
   logic             ovf_q;

   logic [WIDTH-1:0] add_w;
   logic [WIDTH:0]   sub_w;
   logic [SHW-1:0]   shamt;
   logic             add_ovf, sub_ovf, slt, sltu;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;

   assign shamt   = b[SHW-1:0];
   assign add_w   = a + b;
   assign sub_w   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
   assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
   assign slt     = sub_w[WIDTH-1] ^ sub_ovf;
   assign sltu    = ~sub_w[WIDTH];

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (op)
         4'd0: begin alu_res = add_w; alu_ovf = add_ovf; end
         4'd1: begin alu_res = sub_w[WIDTH-1:0]; alu_ovf = sub_ovf; end
         4'd2: alu_res = a << shamt;
         4'd3: alu_res = {{(WIDTH-1){1'b0}}, slt};
         4'd4: alu_res = {{(WIDTH-1){1'b0}}, sltu};
         4'd5: alu_res = a ^ b;
         4'd6: alu_res = a >> shamt;
         4'd7: alu_res = $unsigned($signed(a) >>> shamt);
         4'd8: alu_res = a | b;
         4'd9: alu_res = a & b;
         default: alu_res = '0;
      endcase
   end

`ifdef ALU_SEQ_MULDIV_EN
   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

   // prod_q holds {acc, multiplier} for multiply, and the dividend/quotient in its low half for divide
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   mcand_q, rem_q, rem_d, mul_add, div_diff;
   logic [WIDTH:0]     mul_sum, trial;
   logic [SHW-1:0]     cnt_q;
   logic               is_div_q, sel_q, is_iter, div_ge;
   logic [WIDTH-1:0]   iter_res;

   assign is_iter = (op >= 4'd10) && (op <= 4'd13);

   always_comb begin
      mul_add  = prod_q[0] ? mcand_q : {WIDTH{1'b0}};
      mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
      trial    = {rem_q, prod_q[WIDTH-1]};
      div_ge   = trial >= {1'b0, mcand_q};
      div_diff = trial[WIDTH-1:0] - mcand_q;
      if (is_div_q) begin
         prod_d = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], div_ge};
         rem_d  = div_ge ? div_diff : trial[WIDTH-1:0];
      end else begin
         prod_d = {mul_sum, prod_q[WIDTH-1:1]};
         rem_d  = rem_q;
      end
      if (!sel_q)        iter_res = prod_d[WIDTH-1:0];
      else if (is_div_q) iter_res = rem_d;
      else               iter_res = prod_d[2*WIDTH-1:WIDTH];
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         result_q <= '0;
         ovf_q    <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
         cnt_q    <= '0;
         prod_q   <= '0;
         rem_q    <= '0;
         mcand_q  <= '0;
         is_div_q <= 1'b0;
         sel_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
`ifdef ALU_SEQ_MULDIV_EN
               if (is_iter) begin
                  state_q  <= BUSY;
                  cnt_q    <= '0;
                  is_div_q <= op[2];
                  sel_q    <= op[0];
                  mcand_q  <= op[2] ? b : a;
                  prod_q   <= {{WIDTH{1'b0}}, (op[2] ? a : b)};
                  rem_q    <= '0;
               end else begin
                  result_q <= alu_res;
                  ovf_q    <= alu_ovf;
                  state_q  <= DONE;
               end
`else
               result_q <= alu_res;
               ovf_q    <= alu_ovf;
               state_q  <= DONE;
`endif
            end
`ifdef ALU_SEQ_MULDIV_EN
            BUSY: begin
               prod_q <= prod_d;
               rem_q  <= rem_d;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  result_q <= iter_res;
                  ovf_q    <= 1'b0;
                  state_q  <= DONE;
               end
            end
`endif
            DONE: if (out_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign result      = result_q;
   assign is_zero     = (result_q == '0);
   assign overflow    = ovf_q;
   assign dbg_state_o = state_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked execution unit for the npc datapath and the successor to the single-function adder ALU. It implements the full RV32I integer operation set in one registered cycle. It optionally adds iterative unsigned multiply/divide operations that take several cycles. Operands enter through a valid/ready input port, and results leave through a valid/ready output port with zero and overflow flags.

## Interface
- `WIDTH`, default 32: operand and result width. Must be a power of two and at least 8.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width. Derived from `WIDTH`; never overridden.

Ports (clock and reset first):
- `clk` input 1: the single clock. All state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: the operation request is valid.
- `in_ready` output 1: the unit can accept a request.
- `op` input 4: operation select.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `out_valid` output 1: result valid.
- `out_ready` input 1: the consumer accepts the result.
- `result` output WIDTH: operation result.
- `is_zero` output 1: `result == 0`.
- `overflow` output 1: signed overflow of ADD/SUB. It is 0 for all other ops.

## Operation
- Op encoding:
  - 0 ADD: `a+b`
  - 1 SUB: `a-b`
  - 2 SLL: `a << b[SHW-1:0]`
  - 3 SLT: signed `a<b`, giving 1 or 0
  - 4 SLTU: unsigned `a<b`
  - 5 XOR
  - 6 SRL
  - 7 SRA: arithmetic right shift
  - 8 OR
  - 9 AND
  - 10 MUL: low WIDTH bits of the product
  - 11 MULHU: high WIDTH bits of the unsigned product
  - 12 DIVU
  - 13 REMU
  - 14–15 reserved: result 0, single-cycle
- Arithmetic rules:
  - All arithmetic wraps modulo 2^WIDTH.
  - SLT/SLTU are computed from the SUB path: signed uses `sign ^ overflow`; unsigned uses the inverted borrow.
- Division by zero: DIVU returns all-ones; REMU returns `a`. There is no exception.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: `in_ready=1`. On `in_valid`, the operands and op are latched. Ops 10–13 go to BUSY with the iteration counter set to 0. All other ops compute, register `result`/`overflow`, and go to DONE.
  - BUSY: one iteration per cycle.
    - Multiply is shift-add over a 2·WIDTH product register.
    - Divide is restoring, one quotient bit per cycle, MSB first.
    - After iteration WIDTH-1 the selected half or quotient/remainder is registered and the FSM goes to DONE.
  - DONE: `out_valid=1`. `result`, `is_zero` and `overflow` are held stable. On `out_ready` the FSM returns to IDLE.
- One operation is in flight at a time. `in_ready` is 0 in BUSY and DONE.
- Inputs other than `out_ready` are ignored outside IDLE. Operand changes after acceptance have no effect.

## Timing
- Reset values: state IDLE, `in_ready=1`, `out_valid=0`, `result=0`, `is_zero=1`, `overflow=0`, iteration counter 0.
- Reset mid-operation (BUSY or DONE) aborts: the pending result is discarded and the next cycle shows the reset values.
- Single-cycle ops: accepted at edge N, `out_valid=1` after edge N+1's update, i.e. in cycle N+1.
- Iterative ops: accepted at edge N, `out_valid=1` in cycle N+WIDTH+1.
- Throughput, assuming `out_ready` is tied high:
  - Single-cycle ops: one result every 2 cycles, because DONE→IDLE costs one cycle.
  - Iterative ops: one result every WIDTH+2 cycles.
- `out_ready` held low keeps DONE indefinitely with outputs stable.
- `out_ready` high while `out_valid=0` has no effect.
- `in_valid` is sampled only when `in_ready=1`. There is no combinational path from `in_valid` to `in_ready` or from `out_ready` to `out_valid`.

## Configuration
- Macro `ALU_SEQ_MULDIV_EN`.
- Defined: ops 10–13 are implemented as above. The BUSY state, iteration counter, product register and remainder register are present.
- Undefined:
  - Ops 10–13 behave as reserved: result 0, single-cycle, DONE in cycle N+1.
  - No BUSY state or iterative datapath is synthesised.
  - All other behaviour is identical.

## Test plan
Directed scenarios, `WIDTH=32`:
- Reset → check all reset values. Then ADD `a=0x7FFFFFFF, b=1` → cycle N+1: `result=0x80000000`, `overflow=1`, `is_zero=0`.
- SUB `a=5, b=5` → `result=0`, `is_zero=1`, `overflow=0`. Then:
  - SLT `a=0xFFFFFFFF, b=1` → `result=1`.
  - SLTU with the same operands → `result=0`.
  - SRA `a=0x80000000, b=0x24` (shift 4) → `result=0xF8000000`.
- With `ALU_SEQ_MULDIV_EN`, sample in cycle N+33 with `out_ready` high:
  - MULHU `a=b=0xFFFFFFFF` → `result=0xFFFFFFFE`.
  - MUL with the same operands → `result=1`.
- With `ALU_SEQ_MULDIV_EN`:
  - DIVU `a=100, b=7` → `14`.
  - REMU → `2`.
  - DIVU `b=0` → `0xFFFFFFFF`.
  - REMU `a=9, b=0` → `9`.
- Backpressure: hold `out_ready=0` for 10 cycles after `out_valid`. `result` stays stable and `in_ready` stays 0. A new `in_valid` pulse in that window is ignored.
- Assert `rst` for one cycle in the middle of BUSY on a DIVU. Next cycle shows reset values. A following ADD `2+3` returns `5` in cycle N+1.
